// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the Execute stage; drives the pipeline freeze via busy.
// Optional build macro MDU_DIV_EARLY_EN: divides by zero or with |a| < |b| finish after one DIV cycle.
module mdu_iter #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ext_stall,
  input  logic        flush,
  output logic        busy,
  output logic        valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      opA, opB, rem;
  logic             negQ, negR, divZero;
`ifdef MDU_DIV_EARLY_EN
  logic [31:0]      aRaw;
`endif

  logic        signedOp, mulLast, divLast, divEarly, divFinish, ge;
  logic [31:0] magA, magB, remNext, quoNext, hiDiv, loDiv;
  logic [32:0] shifted;
  logic [63:0] prodMag, product;

  // Operands are held as magnitudes; the sign is reapplied once the result is ready.
  always_comb begin
    signedOp = op[0];
    magA     = (signedOp & a[31]) ? -a : a;
    magB     = (signedOp & b[31]) ? -b : b;
  end

  always_comb begin
    mulLast = (cnt == CNT_W'(MUL_LAT - 1));
    divLast = (cnt == CNT_W'(DIV_ITER - 1));
    prodMag = {32'd0, opA} * {32'd0, opB};
    product = negQ ? -prodMag : prodMag;
    // opA doubles as the dividend shift register and collects quotient bits from the bottom.
    shifted = {rem, opA[31]};
    ge      = (shifted >= {1'b0, opB});
    remNext = ge ? (shifted[31:0] - opB) : shifted[31:0];
    quoNext = {opA[30:0], ge};
`ifdef MDU_DIV_EARLY_EN
    divEarly = (cnt == '0) & (divZero | (opA < opB));
`else
    divEarly = 1'b0;
`endif
    divFinish = divLast | divEarly;
    loDiv     = divZero ? '1 : (negQ ? -quoNext : quoNext);
    hiDiv     = negR ? -remNext : remNext;
`ifdef MDU_DIV_EARLY_EN
    if (divEarly) begin
      loDiv = divZero ? '1 : '0;
      hiDiv = aRaw;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (start) stateNext = op[1] ? DIV : MUL;
      MUL:  if (mulLast) stateNext = DONE;
      DIV:  if (divFinish) stateNext = DONE;
      DONE: if (!ext_stall) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (flush) stateNext = IDLE;
  end

  always_comb begin
    busy  = !flush & (((state == IDLE) & start) | (state == MUL) | (state == DIV));
    valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      opA     <= '0;
      opB     <= '0;
      rem     <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
`ifdef MDU_DIV_EARLY_EN
      aRaw    <= '0;
`endif
      hi      <= '0;
      lo      <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          opA     <= magA;
          opB     <= magB;
          rem     <= '0;
          negQ    <= signedOp & (a[31] ^ b[31]);
          negR    <= signedOp & a[31];
          divZero <= (b == '0);
`ifdef MDU_DIV_EARLY_EN
          aRaw    <= a;
`endif
          cnt     <= '0;
        end
        MUL: begin
          if (mulLast) begin
            {hi, lo} <= product;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DIV: begin
          rem <= remNext;
          opA <= quoNext;
          if (divFinish) begin
            hi  <= hiDiv;
            lo  <= loDiv;
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed ops push expected HI/LO, a monitor checks on each valid rise.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ext_stall = 1'b0;
  logic        flush = 1'b0;
  logic        busy, valid;
  logic [31:0] hi, lo;

  int compared = 0;
  int mismatched = 0;

  string       nameQ[$];
  logic [31:0] expHiQ[$];
  logic [31:0] expLoQ[$];

`ifdef MDU_DIV_EARLY_EN
  localparam int DIV_ZERO_BUSY = 2;
`else
  localparam int DIV_ZERO_BUSY = 33;
`endif

  mdu_iter #(.MUL_LAT(2), .DIV_ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ext_stall(ext_stall), .flush(flush), .busy(busy), .valid(valid),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one pop per rising valid.
  initial begin
    logic prevValid;
    string nm;
    prevValid = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (valid && !prevValid) begin
        if (nameQ.size() == 0) begin
          check("unexpected valid", 32'(valid), 32'd0);
        end else begin
          nm = nameQ.pop_front();
          check({nm, " hi"}, hi, expHiQ.pop_front());
          check({nm, " lo"}, lo, expLoQ.pop_front());
        end
      end
      prevValid = valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eHi, input logic [31:0] eLo,
                       input int eBusy, input bit stall);
    int n;
    nameQ.push_back(name);
    expHiQ.push_back(eHi);
    expLoQ.push_back(eLo);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({name, " busy cycles"}, 32'(n), 32'(eBusy));
    check({name, " valid after busy"}, 32'(valid), 32'd1);
    if (stall) begin
      ext_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
        check({name, " valid in stall"}, 32'(valid), 32'd1);
        check({name, " no restart"}, 32'(busy), 32'd0);
        @(negedge clk);
        #1;
      end
      check({name, " valid stall end"}, 32'(valid), 32'd1);
    end
    start = 1'b0;
    ext_stall = 1'b0;
    @(negedge clk);
    #1;
    check({name, " idle valid"}, 32'(valid), 32'd0);
    check({name, " idle busy"}, 32'(busy), 32'd0);
    check({name, " hi held"}, hi, eHi);
    check({name, " lo held"}, lo, eLo);
  endtask

  initial begin
    int n;
    #1;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    runOp("MULT -2*3",    2'b01, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 3, 1'b0);
    runOp("DIVU 100/7",   2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
    runOp("DIV -7/2",     2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
    runOp("DIV min/-1",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 1'b0);

    // Flush on the tenth DIV iteration: nothing is pushed, prior HI/LO must survive.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    #1;
    n = 0;
    while (busy && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("flush busy before", 32'(n), 32'd10);
    flush = 1'b1;
    #1;
    check("flush busy in flush cycle", 32'(busy), 32'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush busy after", 32'(busy), 32'd0);
    check("flush valid after", 32'(valid), 32'd0);
    check("flush hi kept", hi, 32'h0);
    check("flush lo kept", lo, 32'h80000000);
    repeat (40) @(negedge clk);

    runOp("DIVU 5/0 stall", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, DIV_ZERO_BUSY, 1'b1);
    runOp("DIV 7/-2",     2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 1'b0);
    runOp("MULTU small",  2'b00, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 3, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(negedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    #1;
    check("async rst hi", hi, 32'd0);
    check("async rst lo", lo, 32'd0);
    check("async rst valid", 32'(valid), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runOp("MULTU max*max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3, 1'b0);

    n = 0;
    while (nameQ.size() != 0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("scoreboard drained", 32'(nameQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
